wb_port_arbiter: RTL and testbench

//   Writeback arbiter between the functional units and the physical register file (PRF) / CDB.

---
 rtl/wb_port_arbiter_if.sv | 34 +++
 rtl/wb_port_arbiter.sv | 192 +++++++++++++++++++
 tb/tb_wb_port_arbiter.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_port_arbiter_if.sv
// ---------------------------------------------------------------------------
// wb_port_arbiter_if
//   Bundles the functional-unit completion handshake and the writeback
//   (PRF write / CDB broadcast) slots of wb_port_arbiter.
//   master : functional-unit side. Drives fu_valid/fu_idx/fu_value and sees
//            fu_ready plus the wb_* slots.
//   slave  : arbiter side. Sees fu_* and drives fu_ready and wb_*.
//   Packed layout: entry n of a *_idx / *_value vector sits at
//   [n*PREG_W +: PREG_W] / [n*XLEN +: XLEN].
// ---------------------------------------------------------------------------
interface wb_port_arbiter_if #(
  parameter int NUM_FU = 7,
  parameter int NUM_WB = 3,
  parameter int PREG_W = 6,
  parameter int XLEN   = 32
);
  logic [NUM_FU-1:0]        fu_valid;
  logic [NUM_FU*PREG_W-1:0] fu_idx;
  logic [NUM_FU*XLEN-1:0]   fu_value;
  logic [NUM_FU-1:0]        fu_ready;
  logic [NUM_WB-1:0]        wb_valid;
  logic [NUM_WB*PREG_W-1:0] wb_idx;
  logic [NUM_WB*XLEN-1:0]   wb_value;

  modport master (
    output fu_valid, fu_idx, fu_value,
    input  fu_ready, wb_valid, wb_idx, wb_value
  );

  modport slave (
    input  fu_valid, fu_idx, fu_value,
    output fu_ready, wb_valid, wb_idx, wb_value
  );
endinterface

// File: rtl/wb_port_arbiter.sv
// ---------------------------------------------------------------------------
// wb_port_arbiter
//   Writeback arbiter between NUM_FU functional units and NUM_WB PRF write /
//   CDB slots. Every FU owns a one-entry holding buffer; each cycle up to
//   NUM_WB full buffers are granted round-robin (starting at rr_ptr) and
//   packed, in scan order, into registered writeback slots.
//
// Ports
//   clock_i   : system clock, rising edge
//   reset_i   : synchronous active-high reset
//   squash_i  : synchronous flush; empties buffers and writeback slots
//   bus       : wb_port_arbiter_if.slave (fu_* handshake in, wb_* slots out)
//   perf_conflict_cnt_o : (WB_PERF_CNT_EN only) saturating count of edges
//               where more buffers were full than there are write slots
//
// Build option
//   WB_PERF_CNT_EN : adds perf_conflict_cnt_o and its counter.
// ---------------------------------------------------------------------------
module wb_port_arbiter #(
  parameter int NUM_FU = 7,
  parameter int NUM_WB = 3,
  parameter int PREG_W = 6,
  parameter int XLEN   = 32
) (
  input  logic                   clock_i,
  input  logic                   reset_i,
  input  logic                   squash_i,
  wb_port_arbiter_if.slave       bus
`ifdef WB_PERF_CNT_EN
  ,
  output logic [31:0]            perf_conflict_cnt_o
`endif
);

  localparam int PTR_W  = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;
  localparam int SLOT_W = (NUM_WB > 1) ? $clog2(NUM_WB) : 1;
  localparam int CNT_W  = $clog2(NUM_WB + 1);

  // holding buffers
  logic [NUM_FU-1:0] buf_valid_q, buf_valid_d;
  logic [PREG_W-1:0] buf_idx_q   [NUM_FU];
  logic [PREG_W-1:0] buf_idx_d   [NUM_FU];
  logic [XLEN-1:0]   buf_value_q [NUM_FU];
  logic [XLEN-1:0]   buf_value_d [NUM_FU];

  logic [PTR_W-1:0]  rr_ptr_q, rr_ptr_d;

  // registered writeback slots
  logic [NUM_WB-1:0] wb_valid_q, wb_valid_d;
  logic [PREG_W-1:0] wb_idx_q   [NUM_WB];
  logic [PREG_W-1:0] wb_idx_d   [NUM_WB];
  logic [XLEN-1:0]   wb_value_q [NUM_WB];
  logic [XLEN-1:0]   wb_value_d [NUM_WB];

  // arbitration scratch
  logic [NUM_FU-1:0] grant;
  logic [NUM_FU-1:0] ready;
  logic [CNT_W-1:0]  n_grant;
  logic [PTR_W-1:0]  last_fu;
  logic [PTR_W:0]    scan_sum;
  logic [PTR_W-1:0]  scan_fu;

  logic [PREG_W-1:0] fu_idx_w   [NUM_FU];
  logic [XLEN-1:0]   fu_value_w [NUM_FU];

  for (genvar i = 0; i < NUM_FU; i++) begin : g_fu_unpack
    assign fu_idx_w[i]   = bus.fu_idx[i*PREG_W +: PREG_W];
    assign fu_value_w[i] = bus.fu_value[i*XLEN +: XLEN];
  end

  // Round-robin scan from rr_ptr; the first NUM_WB full buffers win and
  // occupy slots 0,1,... in the order they are found.
  always_comb begin
    grant      = '0;
    n_grant    = '0;
    last_fu    = rr_ptr_q;
    scan_sum   = '0;
    scan_fu    = '0;
    wb_valid_d = '0;
    for (int s = 0; s < NUM_WB; s++) begin
      wb_idx_d[s]   = '0;
      wb_value_d[s] = '0;
    end
    for (int k = 0; k < NUM_FU; k++) begin
      // rr_ptr and k are both below NUM_FU, so one subtraction wraps.
      scan_sum = {1'b0, rr_ptr_q} + (PTR_W+1)'(k);
      if (scan_sum >= (PTR_W+1)'(NUM_FU)) begin
        scan_sum = scan_sum - (PTR_W+1)'(NUM_FU);
      end
      scan_fu = scan_sum[PTR_W-1:0];
      if (buf_valid_q[scan_fu] && (n_grant < CNT_W'(NUM_WB))) begin
        grant[scan_fu]                        = 1'b1;
        last_fu                               = scan_fu;
        wb_valid_d[n_grant[SLOT_W-1:0]]       = 1'b1;
        wb_idx_d[n_grant[SLOT_W-1:0]]         = buf_idx_q[scan_fu];
        wb_value_d[n_grant[SLOT_W-1:0]]       = buf_value_q[scan_fu];
        n_grant                               = n_grant + CNT_W'(1);
      end
    end
  end

  // A draining buffer can accept a new result in the same cycle.
  always_comb begin
    ready = ~buf_valid_q | grant;
  end

  assign bus.fu_ready = ready;

  always_comb begin
    buf_valid_d = buf_valid_q;
    buf_idx_d   = buf_idx_q;
    buf_value_d = buf_value_q;
    rr_ptr_d    = rr_ptr_q;
    if (n_grant != '0) begin
      rr_ptr_d = (last_fu == PTR_W'(NUM_FU - 1)) ? '0 : last_fu + PTR_W'(1);
    end
    for (int i = 0; i < NUM_FU; i++) begin
      if (grant[i]) begin
        buf_valid_d[i] = 1'b0;
      end
      // Results for r0 complete the handshake but are discarded.
      if (bus.fu_valid[i] && ready[i] && (fu_idx_w[i] != '0)) begin
        buf_valid_d[i] = 1'b1;
        buf_idx_d[i]   = fu_idx_w[i];
        buf_value_d[i] = fu_value_w[i];
      end
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      buf_valid_q <= '0;
      rr_ptr_q    <= '0;
      wb_valid_q  <= '0;
      for (int i = 0; i < NUM_FU; i++) begin
        buf_idx_q[i]   <= '0;
        buf_value_q[i] <= '0;
      end
      for (int s = 0; s < NUM_WB; s++) begin
        wb_idx_q[s]   <= '0;
        wb_value_q[s] <= '0;
      end
    end else if (squash_i) begin
      // rr_ptr deliberately keeps its position across a flush.
      buf_valid_q <= '0;
      wb_valid_q  <= '0;
      for (int s = 0; s < NUM_WB; s++) begin
        wb_idx_q[s]   <= '0;
        wb_value_q[s] <= '0;
      end
    end else begin
      buf_valid_q <= buf_valid_d;
      buf_idx_q   <= buf_idx_d;
      buf_value_q <= buf_value_d;
      rr_ptr_q    <= rr_ptr_d;
      wb_valid_q  <= wb_valid_d;
      wb_idx_q    <= wb_idx_d;
      wb_value_q  <= wb_value_d;
    end
  end

  for (genvar s = 0; s < NUM_WB; s++) begin : g_wb_pack
    assign bus.wb_valid[s]                 = wb_valid_q[s];
    assign bus.wb_idx[s*PREG_W +: PREG_W]  = wb_idx_q[s];
    assign bus.wb_value[s*XLEN +: XLEN]    = wb_value_q[s];
  end

`ifdef WB_PERF_CNT_EN
  logic [31:0] perf_cnt_q, perf_cnt_d;
  logic        conflict;

  // Squash does not clear the counter; only reset does.
  always_comb begin
    conflict   = ($countones(buf_valid_q) > NUM_WB);
    perf_cnt_d = perf_cnt_q;
    if (conflict && (perf_cnt_q != 32'hFFFF_FFFF)) begin
      perf_cnt_d = perf_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      perf_cnt_q <= '0;
    end else begin
      perf_cnt_q <= perf_cnt_d;
    end
  end

  assign perf_conflict_cnt_o = perf_cnt_q;
`endif

endmodule

// File: tb/tb_wb_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_wb_port_arbiter
//   Self-checking bench for wb_port_arbiter. A transaction-level model keeps
//   per-FU pending results and a round-robin pointer; after every clock edge
//   the DUT slots, fu_ready (and the perf counter when WB_PERF_CNT_EN is
//   defined) are compared against it. Directed scenarios add hand-computed
//   expectations, followed by a long randomized run.
// ---------------------------------------------------------------------------
module tb_wb_port_arbiter;
  localparam int NUM_FU = 7;
  localparam int NUM_WB = 3;
  localparam int PREG_W = 6;
  localparam int XLEN   = 32;

  logic clk = 1'b0;
  logic rst;
  logic sq;

  always #5 clk = ~clk;

  wb_port_arbiter_if #(.NUM_FU(NUM_FU), .NUM_WB(NUM_WB), .PREG_W(PREG_W), .XLEN(XLEN)) bus ();

`ifdef WB_PERF_CNT_EN
  logic [31:0] perf_cnt;
`endif

  wb_port_arbiter #(.NUM_FU(NUM_FU), .NUM_WB(NUM_WB), .PREG_W(PREG_W), .XLEN(XLEN)) dut (
    .clock_i             (clk),
    .reset_i             (rst),
    .squash_i            (sq),
    .bus                 (bus)
`ifdef WB_PERF_CNT_EN
    ,
    .perf_conflict_cnt_o (perf_cnt)
`endif
  );

  int n_cmp = 0;
  int n_bad = 0;

  // stimulus currently presented by each FU
  bit          cur_rst;
  bit          cur_sq;
  bit          cur_v   [NUM_FU];
  int          cur_idx [NUM_FU];
  logic [31:0] cur_val [NUM_FU];

  // reference model
  bit          m_bv    [NUM_FU];
  int          m_bidx  [NUM_FU];
  logic [31:0] m_bval  [NUM_FU];
  int          m_rr;
  bit          m_wbv   [NUM_WB];
  int          m_wbidx [NUM_WB];
  logic [31:0] m_wbval [NUM_WB];
  logic [31:0] m_perf;
  bit          m_acc   [NUM_FU];
  logic [NUM_FU-1:0] m_rdy;
  int          m_g[$];

  task automatic check(string name, logic [255:0] act, logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // FUs granted this cycle, in scan order
  function automatic void compute_grants();
    m_g.delete();
    for (int k = 0; k < NUM_FU; k++) begin
      int f = (m_rr + k) % NUM_FU;
      if (m_bv[f] && m_g.size() < NUM_WB) m_g.push_back(f);
    end
  endfunction

  function automatic void compute_ready();
    compute_grants();
    for (int i = 0; i < NUM_FU; i++) m_rdy[i] = !m_bv[i];
    foreach (m_g[j]) m_rdy[m_g[j]] = 1'b1;
  endfunction

  // advance the model across one rising edge using the inputs held before it
  task automatic model_step();
    int nfull;
    compute_ready();
    for (int i = 0; i < NUM_FU; i++) m_acc[i] = cur_v[i] && m_rdy[i];
    if (cur_rst) begin
      for (int i = 0; i < NUM_FU; i++) begin
        m_bv[i] = 0; m_bidx[i] = 0; m_bval[i] = '0;
      end
      for (int s = 0; s < NUM_WB; s++) begin
        m_wbv[s] = 0; m_wbidx[s] = 0; m_wbval[s] = '0;
      end
      m_rr   = 0;
      m_perf = '0;
    end else begin
      nfull = 0;
      for (int i = 0; i < NUM_FU; i++) nfull += int'(m_bv[i]);
      if (nfull > NUM_WB && m_perf != 32'hFFFF_FFFF) m_perf = m_perf + 32'd1;
      for (int s = 0; s < NUM_WB; s++) begin
        m_wbv[s] = 0; m_wbidx[s] = 0; m_wbval[s] = '0;
      end
      if (cur_sq) begin
        for (int i = 0; i < NUM_FU; i++) m_bv[i] = 0;
      end else begin
        foreach (m_g[j]) begin
          m_wbv[j]   = 1;
          m_wbidx[j] = m_bidx[m_g[j]];
          m_wbval[j] = m_bval[m_g[j]];
          m_bv[m_g[j]] = 0;
        end
        if (m_g.size() > 0) m_rr = (m_g[m_g.size()-1] + 1) % NUM_FU;
        for (int i = 0; i < NUM_FU; i++) begin
          if (m_acc[i] && cur_idx[i] != 0) begin
            m_bv[i] = 1; m_bidx[i] = cur_idx[i]; m_bval[i] = cur_val[i];
          end
        end
      end
    end
    compute_ready();
  endtask

  task automatic compare();
    logic [NUM_WB-1:0]        ev;
    logic [NUM_WB*PREG_W-1:0] ei;
    logic [NUM_WB*XLEN-1:0]   ex;
    for (int s = 0; s < NUM_WB; s++) begin
      ev[s] = m_wbv[s];
      ei[s*PREG_W +: PREG_W] = PREG_W'(m_wbidx[s]);
      ex[s*XLEN +: XLEN]     = m_wbval[s];
    end
    check("wb_valid", bus.wb_valid, ev);
    check("wb_idx",   bus.wb_idx,   ei);
    check("wb_value", bus.wb_value, ex);
    check("fu_ready", bus.fu_ready, m_rdy);
`ifdef WB_PERF_CNT_EN
    check("perf_cnt", perf_cnt, m_perf);
`endif
  endtask

  task automatic drive();
    rst = cur_rst;
    sq  = cur_sq;
    for (int i = 0; i < NUM_FU; i++) begin
      bus.fu_valid[i]                 = cur_v[i];
      bus.fu_idx[i*PREG_W +: PREG_W]  = PREG_W'(cur_idx[i]);
      bus.fu_value[i*XLEN +: XLEN]    = cur_val[i];
    end
  endtask

  // one clock: present inputs, let the edge happen, check, retire handshakes
  task automatic cycle();
    drive();
    @(negedge clk);
    model_step();
    compare();
    for (int i = 0; i < NUM_FU; i++) if (m_acc[i]) cur_v[i] = 0;
  endtask

  task automatic all_valid(int base);
    for (int i = 0; i < NUM_FU; i++) begin
      cur_v[i] = 1; cur_idx[i] = i + 1; cur_val[i] = 32'(base + i + 1);
    end
  endtask

  initial begin
    int rate;
    cur_rst = 1; cur_sq = 0;
    for (int i = 0; i < NUM_FU; i++) begin
      cur_v[i] = 0; cur_idx[i] = 0; cur_val[i] = '0;
    end

    // reset held two cycles
    cycle(); cycle();
    check("rst_wb_valid", bus.wb_valid, 3'b000);
    check("rst_wb_idx",   bus.wb_idx,   18'd0);
    check("rst_wb_value", bus.wb_value, 96'd0);
    check("rst_fu_ready", bus.fu_ready, 7'h7F);
    cur_rst = 0;
    cycle();
    check("post_rst_ready", bus.fu_ready, 7'h7F);

    // single result, minimum latency
    cur_v[3] = 1; cur_idx[3] = 5; cur_val[3] = 32'hDEAD_BEEF;
    cycle();
    check("lat_edge_t", bus.wb_valid, 3'b000);
    cycle();
    check("lat_valid", bus.wb_valid, 3'b001);
    check("lat_idx",   bus.wb_idx,   {12'd0, 6'd5});
    check("lat_value", bus.wb_value, {64'd0, 32'hDEAD_BEEF});
    cycle();
    check("lat_after", bus.wb_valid, 3'b000);

    // all FUs complete at once from rr_ptr=0
    cur_rst = 1; cycle(); cycle(); cur_rst = 0;
    all_valid(0);
    cycle();
    check("all_ready_a", bus.fu_ready, 7'h07);
    check("all_wb_a",    bus.wb_valid, 3'b000);
    cycle();
    check("all_wb_b",    bus.wb_valid, 3'b111);
    check("all_idx_b",   bus.wb_idx,   {6'd3, 6'd2, 6'd1});
    check("all_ready_b", bus.fu_ready, 7'h3F);
    cycle();
    check("all_idx_c",   bus.wb_idx,   {6'd6, 6'd5, 6'd4});
    check("all_ready_c", bus.fu_ready, 7'h7F);
    cycle();
    check("all_wb_d",    bus.wb_valid, 3'b001);
    check("all_idx_d",   bus.wb_idx,   {12'd0, 6'd7});
    check("all_val_d",   bus.wb_value, {64'd0, 32'd7});
    cycle();
    check("all_wb_e",    bus.wb_valid, 3'b000);

    // write to r0 is dropped
    check("r0_ready", bus.fu_ready[1], 1'b1);
    cur_v[1] = 1; cur_idx[1] = 0; cur_val[1] = 32'd100;
    cycle();
    for (int c = 0; c < 4; c++) begin
      cycle();
      check("r0_no_wb", bus.wb_valid, 3'b000);
    end

    // squash with every buffer full
    all_valid(32'h100);
    cycle();
    check("sq_full_ready", bus.fu_ready, 7'h07);
    cur_sq = 1;
    cycle();
    cur_sq = 0;
    check("sq_wb_valid", bus.wb_valid, 3'b000);
    check("sq_ready",    bus.fu_ready, 7'h7F);
    for (int c = 0; c < 3; c++) begin
      cycle();
      check("sq_no_wb", bus.wb_valid, 3'b000);
    end

`ifdef WB_PERF_CNT_EN
    cur_rst = 1; cycle(); cur_rst = 0;
    check("perf_rst", perf_cnt, 32'd0);
    for (int c = 0; c < 10; c++) begin
      all_valid(0);
      cycle();
    end
    for (int i = 0; i < NUM_FU; i++) cur_v[i] = 0;
    for (int c = 0; c < 4; c++) cycle();
    check("perf_count", perf_cnt, 32'd11);
    cur_rst = 1; cycle(); cur_rst = 0;
    check("perf_clear", perf_cnt, 32'd0);
`endif

    // randomized traffic with occasional squash and reset
    rate = 50;
    for (int c = 0; c < 3000; c++) begin
      if (c % 200 == 0) rate = $urandom_range(10, 100);
      cur_rst = ($urandom_range(0, 399) == 0);
      cur_sq  = ($urandom_range(0, 59) == 0);
      for (int i = 0; i < NUM_FU; i++) begin
        if (!cur_v[i] && $urandom_range(0, 99) < rate) begin
          cur_v[i]   = 1;
          cur_idx[i] = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 63);
          cur_val[i] = $urandom;
        end
      end
      cycle();
    end
    cur_rst = 0; cur_sq = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
